// File: rtl/led_pattern_sequencer_if.sv
// Command pulses from the button front end and the resulting LED display state.
interface led_pattern_sequencer_if #(
    parameter int LED_W = 16
) ();
    logic             mode_next;
    logic             speed_up;
    logic             speed_down;
    logic             pause_toggle;
    logic [LED_W-1:0] led_out;
    logic [1:0]       mode;
    logic [1:0]       speed;
    logic             paused;
    logic             step_strobe;

    modport master (
        output mode_next, speed_up, speed_down, pause_toggle,
        input  led_out, mode, speed, paused, step_strobe
    );

    modport slave (
        input  mode_next, speed_up, speed_down, pause_toggle,
        output led_out, mode, speed, paused, step_strobe
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: selectable pattern modes and step rates with pause/resume.
// A prescaler makes base ticks; a per-speed divider on those ticks decides when led_out steps.
module led_pattern_sequencer #(
    parameter int BASE_DIV = 1_250_000,
    parameter int LED_W    = 16
) (
    input logic                     clk,
    input logic                     reset_n,
    led_pattern_sequencer_if.slave  bus
);
    localparam int PRE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BASE_DIV - 1);

    localparam logic [1:0] MODE_ROT_L   = 2'd0;
    localparam logic [1:0] MODE_ROT_R   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE  = 2'd2;
    localparam logic [1:0] MODE_BIN_CNT = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    logic [LED_W-1:0] led_q, led_d, led_step;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       speed_q, speed_d;
    logic             paused_q, paused_d;
    logic             strobe_q, strobe_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       step_cnt_q, step_cnt_d;
    logic             dir_q, dir_d, dir_step;

    logic [2:0] div_last;
    logic       run;
    logic       base_tick;
    logic       step_due;
    logic       speed_inc;
    logic       speed_dec;

    always_comb begin
        unique case (speed_q)
            2'd0:    div_last = 3'd7;
            2'd1:    div_last = 3'd3;
            2'd2:    div_last = 3'd1;
            default: div_last = 3'd0;
        endcase
    end

    // Counting stops in the same cycle a pause is requested, so a step can never
    // land while paused; a resume pulse counts immediately.
    assign run       = ~paused_d;
    assign base_tick = run && (pre_q == PRE_LAST);
    assign step_due  = base_tick && (step_cnt_q == div_last);
    assign speed_inc = bus.speed_up && !bus.speed_down && (speed_q != 2'd3);
    assign speed_dec = bus.speed_down && !bus.speed_up && (speed_q != 2'd0);

    always_comb begin
        led_step = led_q;
        dir_step = dir_q;
        unique case (mode_q)
            MODE_ROT_L: led_step = {led_q[LED_W-2:0], led_q[LED_W-1]};
            MODE_ROT_R: led_step = {led_q[0], led_q[LED_W-1:1]};
            MODE_BOUNCE: begin
                // Turn on the end bit itself so each end value appears only once.
                if (dir_q == DIR_LEFT) begin
                    if (led_q[LED_W-1]) begin
                        dir_step = DIR_RIGHT;
                        led_step = led_q >> 1;
                    end else begin
                        led_step = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        dir_step = DIR_LEFT;
                        led_step = led_q << 1;
                    end else begin
                        led_step = led_q >> 1;
                    end
                end
            end
            MODE_BIN_CNT: led_step = led_q + LED_W'(1);
        endcase
    end

    always_comb begin
        led_d      = led_q;
        mode_d     = mode_q;
        speed_d    = speed_q;
        paused_d   = paused_q ^ bus.pause_toggle;
        strobe_d   = 1'b0;
        pre_d      = pre_q;
        step_cnt_d = step_cnt_q;
        dir_d      = dir_q;

        if (speed_inc) begin
            speed_d = speed_q + 2'd1;
        end else if (speed_dec) begin
            speed_d = speed_q - 2'd1;
        end

        if (bus.mode_next) begin
            mode_d     = mode_q + 2'd1;
            led_d      = (mode_q == MODE_BOUNCE) ? '0 : LED_W'(1);
            dir_d      = DIR_LEFT;
            pre_d      = '0;
            step_cnt_d = '0;
        end else begin
            if (run) begin
                pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
            end
            if (step_due) begin
                step_cnt_d = '0;
                led_d      = led_step;
                dir_d      = dir_step;
                strobe_d   = 1'b1;
            end else if (base_tick) begin
                step_cnt_d = step_cnt_q + 3'd1;
            end
            if (speed_inc || speed_dec) begin
                step_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q      <= LED_W'(1);
            mode_q     <= MODE_ROT_L;
            speed_q    <= 2'd0;
            paused_q   <= 1'b0;
            strobe_q   <= 1'b0;
            pre_q      <= '0;
            step_cnt_q <= 3'd0;
            dir_q      <= DIR_LEFT;
        end else begin
            led_q      <= led_d;
            mode_q     <= mode_d;
            speed_q    <= speed_d;
            paused_q   <= paused_d;
            strobe_q   <= strobe_d;
            pre_q      <= pre_d;
            step_cnt_q <= step_cnt_d;
            dir_q      <= dir_d;
        end
    end

    assign bus.led_out     = led_q;
    assign bus.mode        = mode_q;
    assign bus.speed       = speed_q;
    assign bus.paused      = paused_q;
    assign bus.step_strobe = strobe_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomized bench for led_pattern_sequencer: a step-count reference model predicts strobes
// into a scoreboard queue; a negedge monitor checks strobes and status every cycle.
module tb_led_pattern_sequencer;
    localparam int BD = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rst_s_n = 1'b0;
    always #5 clk = ~clk;

    led_pattern_sequencer_if #(.LED_W(16)) bus ();
    led_pattern_sequencer_if #(.LED_W(4))  s_bus ();

    led_pattern_sequencer #(.BASE_DIV(BD), .LED_W(16)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Small instance used to see the binary counter wrap within a short run.
    led_pattern_sequencer #(.BASE_DIV(2), .LED_W(4)) u_small (
        .clk     (clk),
        .reset_n (rst_s_n),
        .bus     (s_bus)
    );

    typedef struct {
        int          cyc;
        logic [15:0] led;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    bit   small_done = 1'b0;
    int   first_strobe_cyc = -1;
    int   last_strobe_cyc = -1;

    // Reference model: pattern is a function of mode and steps taken since the seed.
    int m_mode, m_speed, m_pre, m_ticks, m_k;
    bit m_paused, m_strobe;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] led_of(input int mode, input int k);
        int p;
        logic [15:0] one;
        one = 16'd1;
        case (mode)
            0: return one << (k % 16);
            1: return one << ((16 - (k % 16)) % 16);
            2: begin
                p = k % 30;
                return one << ((p <= 15) ? p : 30 - p);
            end
            default: return 16'(k);
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_speed = 0; m_pre = 0; m_ticks = 0; m_k = 0;
        m_paused = 1'b0; m_strobe = 1'b0;
    endtask

    function automatic bit due_next();
        return !m_paused && (m_pre == BD - 1) && (m_ticks == (8 >> m_speed) - 1);
    endfunction

    // Called at posedge+1: apply inputs for the coming edge, predict it, then commit.
    task automatic drive(input bit mn, input bit su, input bit sd, input bit pt);
        int dm1, n_mode, n_speed, n_pre, n_ticks, n_k;
        bit run, tick, due, spc, n_paused, n_strobe;
        bus.mode_next = mn; bus.speed_up = su; bus.speed_down = sd; bus.pause_toggle = pt;
        dm1  = (8 >> m_speed) - 1;
        run  = !(m_paused ^ pt);
        tick = run && (m_pre == BD - 1);
        due  = tick && (m_ticks == dm1);
        spc  = (su != sd) && (su ? (m_speed != 3) : (m_speed != 0));
        n_mode = m_mode; n_speed = m_speed; n_pre = m_pre; n_ticks = m_ticks; n_k = m_k;
        n_paused = m_paused ^ pt;
        n_strobe = 1'b0;
        if (spc) n_speed = su ? m_speed + 1 : m_speed - 1;
        if (mn) begin
            n_mode = (m_mode + 1) % 4; n_k = 0; n_pre = 0; n_ticks = 0;
        end else begin
            if (run) n_pre = (m_pre + 1) % BD;
            if (due) begin
                n_ticks = 0; n_k = m_k + 1; n_strobe = 1'b1;
                sb_q.push_back('{cyc: cyc + 1, led: led_of(m_mode, m_k + 1)});
            end else if (tick) begin
                n_ticks = m_ticks + 1;
            end
            if (spc) n_ticks = 0;
        end
        @(posedge clk);
        #1;
        m_mode = n_mode; m_speed = n_speed; m_pre = n_pre; m_ticks = n_ticks; m_k = n_k;
        m_paused = n_paused; m_strobe = n_strobe;
        bus.mode_next = 1'b0; bus.speed_up = 1'b0; bus.speed_down = 1'b0;
        bus.pause_toggle = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            check("led_out", 32'(bus.led_out), 32'(led_of(m_mode, m_k)));
            check("mode", 32'(bus.mode), m_mode);
            check("speed", 32'(bus.speed), m_speed);
            check("paused", 32'(bus.paused), 32'(m_paused));
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                total++; bad++;
                $display("FAIL strobe_missed: got none, expected at cyc %0d", sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
            if (bus.step_strobe) begin
                if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
                last_strobe_cyc = cyc;
                total++;
                if (sb_q.size() == 0 || sb_q[0].cyc != cyc) begin
                    bad++;
                    $display("FAIL strobe_unexpected: got strobe at cyc %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("strobe_led", 32'(bus.led_out), 32'(e.led));
                end
            end
        end
    end

    // Wrap check on the 4-bit instance: BIN_CNT at top speed must run ...E, F, 0, 1...
    initial begin
        int exp_led;
        bit got;
        s_bus.mode_next = 1'b0; s_bus.speed_up = 1'b0;
        s_bus.speed_down = 1'b0; s_bus.pause_toggle = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_s_n = 1'b1;
        repeat (3) begin
            s_bus.mode_next = 1'b1; @(posedge clk); #1; s_bus.mode_next = 1'b0;
        end
        check("small_seed", 32'(s_bus.led_out), 32'd0);
        check("small_mode", 32'(s_bus.mode), 32'd3);
        repeat (3) begin
            s_bus.speed_up = 1'b1; @(posedge clk); #1; s_bus.speed_up = 1'b0;
        end
        check("small_speed", 32'(s_bus.speed), 32'd3);
        exp_led = 0;
        for (int i = 0; i < 20; i++) begin
            got = 1'b0;
            for (int w = 0; w < 20 && !got; w++) begin
                @(negedge clk);
                got = s_bus.step_strobe;
            end
            exp_led = (exp_led + 1) & 15;
            if (!got) begin
                total++; bad++;
                $display("FAIL small_timeout: got no strobe, expected led %0h", exp_led);
            end else begin
                check("small_count", 32'(s_bus.led_out), exp_led);
            end
        end
        small_done = 1'b1;
    end

    initial begin
        int c0, r0, guard;
        model_reset();
        bus.mode_next = 1'b0; bus.speed_up = 1'b0; bus.speed_down = 1'b0;
        bus.pause_toggle = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_led", 32'(bus.led_out), 32'd1);
        check("rst_mode", 32'(bus.mode), 32'd0);
        check("rst_strobe", 32'(bus.step_strobe), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en = 1'b1;
        c0 = cyc;

        // Speed 0: full ROT_L lap, strobes every 32 cycles.
        idle(17 * 32 + 2);
        check("first_strobe_delay", first_strobe_cyc - c0, 32);

        // Saturating speed_up, then simultaneous up/down is ignored.
        repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(20);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(10);

        // Into BOUNCE, run past both turns; then BIN_CNT.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4 * 40);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4 * 20);

        // Pause two cycles into a step, hold, resume.
        guard = 0;
        while (!m_strobe && guard < 100) begin idle(1); guard++; end
        idle(2);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(100);
        r0 = cyc;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        check("resume_delay", last_strobe_cyc - r0, 2);

        // mode_next exactly when a step is due.
        guard = 0;
        while (!due_next() && guard < 100) begin idle(1); guard++; end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Randomized commands.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
                  $urandom_range(0, 14) == 0, $urandom_range(0, 29) == 0);
        end
        if (m_paused) drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(40);

        // Asynchronous reset between clock edges.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        if (m_speed == 0) drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        chk_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_led", 32'(bus.led_out), 32'd1);
        check("async_mode", 32'(bus.mode), 32'd0);
        check("async_speed", 32'(bus.speed), 32'd0);
        check("async_paused", 32'(bus.paused), 32'd0);
        check("async_strobe", 32'(bus.step_strobe), 32'd0);
        sb_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en = 1'b1;
        idle(70);

        guard = 0;
        while (!small_done && guard < 500) begin @(posedge clk); guard++; end
        if (!small_done) begin
            total++; bad++;
            $display("FAIL small_done: got not finished, expected finished");
        end
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
